// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with optional return-address stack (macro PC_GEN_RAS_EN); pc/ce registered, ras_hit_o combinational.
// stall[0] freezes the PC and RAS; priority is flush > branch > RAS return > pc+4.
module pc_gen #(
  parameter int          AW        = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int          RAS_DEPTH = 4,
  parameter int          STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [AW-1:0]      new_pc,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [AW-1:0]      branch_target_address_i,
  input  logic               call_i,
  input  logic               ret_i,
  output logic [AW-1:0]      pc,
  output logic               ce,
  output logic               ras_hit_o,
  output logic               ras_empty_o
);

  logic          r_ce;
  logic [AW-1:0] r_pc;
  logic          w_adv;
  logic          w_hit;
  logic [AW-1:0] w_ret_pc;
  logic [AW-1:0] w_next_pc;

  assign w_adv = r_ce & ~stall[0];

  always_ff @(posedge clk) begin
    if (rst) r_ce <= 1'b0;
    else     r_ce <= 1'b1;
  end

  always_comb begin
    w_next_pc = r_pc + AW'(4);
    if (flush)              w_next_pc = new_pc;
    else if (branch_flag_i) w_next_pc = branch_target_address_i;
    else if (w_hit)         w_next_pc = w_ret_pc;
  end

  always_ff @(posedge clk) begin
    if (!r_ce)      r_pc <= RESET_PC;
    else if (w_adv) r_pc <= w_next_pc;
  end

`ifdef PC_GEN_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0] r_top;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_top_inc;
  logic [AW-1:0] w_link;
  logic          w_free;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_empty   = (r_cnt == '0);
  assign w_free    = w_adv & ~flush & ~branch_flag_i;
  assign w_hit     = w_free & ret_i & ~w_empty;
  assign w_push    = w_free & call_i;
  assign w_pop     = w_hit & ~call_i;
  assign w_top_inc = r_top + 1'b1;
  assign w_link    = r_pc + AW'(8);
  assign w_ret_pc  = r_ras[r_top];

  // A call and return together on a live entry swap the top in place.
  always_ff @(posedge clk) begin
    if (w_push) begin
      if (w_hit) r_ras[r_top]     <= w_link;
      else       r_ras[w_top_inc] <= w_link;
    end
  end

  // Pointer wraps naturally, so a full push overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (!r_ce || (w_adv && flush)) begin
      r_cnt <= '0;
      r_top <= '0;
    end else if (w_push && !w_hit) begin
      r_top <= w_top_inc;
      if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + 1'b1;
    end else if (w_pop) begin
      r_top <= r_top - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign ras_empty_o = w_empty;

  logic w_unused;
  assign w_unused = &{1'b0, stall};
`else
  assign w_hit       = 1'b0;
  assign w_ret_pc    = '0;
  assign ras_empty_o = 1'b1;

  logic w_unused;
  assign w_unused = &{1'b0, stall, call_i, ret_i};
`endif

  assign ras_hit_o = w_hit;
  assign pc        = r_pc;
  assign ce        = r_ce;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; RAS scenarios are added when PC_GEN_RAS_EN is defined.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] new_pc;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        call_i;
  logic        ret_i;
  logic [31:0] pc;
  logic        ce;
  logic        ras_hit_o;
  logic        ras_empty_o;

  int n_chk = 0;
  int n_err = 0;

  pc_gen dut (
    .clk                    (clk),
    .rst                    (rst),
    .flush                  (flush),
    .new_pc                 (new_pc),
    .stall                  (stall),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .call_i                 (call_i),
    .ret_i                  (ret_i),
    .pc                     (pc),
    .ce                     (ce),
    .ras_hit_o              (ras_hit_o),
    .ras_empty_o            (ras_empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] tgt);
    branch_flag_i = 1'b1;
    branch_target_address_i = tgt;
    step();
    branch_flag_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; new_pc = '0; stall = '0;
    branch_flag_i = 1'b0; branch_target_address_i = '0;
    call_i = 1'b0; ret_i = 1'b0;

    // reset held three edges
    step();
    chk("rst_ce0", ce, 0);
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_empty", ras_empty_o, 1);
    step();
    rst = 1'b0;
    step();
    chk("ce_up", ce, 1);
    chk("pc_first", pc, 32'h0);
    step();
    chk("pc_4", pc, 32'h4);
    step();
    chk("pc_8", pc, 32'h8);

    // priority: flush beats branch beats return
    jump(32'h100);
    chk("br_100", pc, 32'h100);
    flush = 1'b1; new_pc = 32'h380;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h200; ret_i = 1'b1;
    #1 chk("prio_hit", ras_hit_o, 0);
    step();
    chk("prio_pc", pc, 32'h380);
    chk("prio_empty", ras_empty_o, 1);
    flush = 1'b0;
    step();
    chk("br_over_ret", pc, 32'h200);
    branch_flag_i = 1'b0; ret_i = 1'b0;

    // stall holds pc and ignores call
    jump(32'h60);
    stall = 6'b000001; call_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h60);
      chk("stall_empty", ras_empty_o, 1);
    end
    stall = 6'b111110; call_i = 1'b0;
    step();
    chk("upper_stall_ignored", pc, 32'h64);
    stall = 6'b000001; flush = 1'b1; new_pc = 32'h700;
    step();
    chk("stall_flush", pc, 32'h64);
    stall = '0;
    step();
    chk("flush_pc", pc, 32'h700);
    flush = 1'b0;

    // modulo-2^32 wrap
    jump(32'hFFFF_FFFC);
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_0", pc, 32'h0);

`ifndef PC_GEN_RAS_EN
    // without RAS, call/ret do nothing
    jump(32'h40);
    call_i = 1'b1;
    step();
    call_i = 1'b0;
    chk("noras_call", pc, 32'h44);
    ret_i = 1'b1;
    #1 chk("noras_hit", ras_hit_o, 0);
    step();
    ret_i = 1'b0;
    chk("noras_ret", pc, 32'h48);
    chk("noras_empty", ras_empty_o, 1);
`else
    // simple call/return
    jump(32'h40);
    call_i = 1'b1;
    step();
    call_i = 1'b0;
    chk("call_pc", pc, 32'h44);
    chk("call_nonempty", ras_empty_o, 0);
    jump(32'h90);
    ret_i = 1'b1;
    #1 chk("ret_hit", ras_hit_o, 1);
    step();
    ret_i = 1'b0;
    chk("ret_pc", pc, 32'h48);
    chk("ret_empty", ras_empty_o, 1);

    // overflow: five calls, five returns
    for (int k = 1; k <= 5; k++) begin
      jump(32'h10 * k);
      call_i = 1'b1;
      step();
      call_i = 1'b0;
    end
    ret_i = 1'b1;
    for (int k = 5; k >= 2; k--) begin
      #1 chk("ovf_hit", ras_hit_o, 1);
      step();
      chk("ovf_pc", pc, 32'h10 * k + 32'h8);
    end
    #1 chk("ovf_miss", ras_hit_o, 0);
    step();
    chk("ovf_last", pc, 32'h2C);
    chk("ovf_empty", ras_empty_o, 1);
    ret_i = 1'b0;

    // call+ret on a live entry replaces the top
    jump(32'h10);
    call_i = 1'b1;
    step();
    ret_i = 1'b1;
    #1 chk("swap_hit", ras_hit_o, 1);
    step();
    call_i = 1'b0;
    chk("swap_pc", pc, 32'h18);
    step();
    ret_i = 1'b0;
    chk("swap_ret", pc, 32'h1C);
    chk("swap_empty", ras_empty_o, 1);

    // call+ret on empty pushes, pc+4; stall leaves RAS; flush clears
    jump(32'h80);
    call_i = 1'b1; ret_i = 1'b1;
    step();
    chk("cr_empty_pc", pc, 32'h84);
    chk("cr_empty_push", ras_empty_o, 0);
    ret_i = 1'b0; stall = 6'b000001;
    step();
    chk("stall_ras_pc", pc, 32'h84);
    stall = '0;
    jump(32'h300);
    ret_i = 1'b1;
    step();
    chk("stall_ras_ret", pc, 32'h88);
    ret_i = 1'b0;
    call_i = 1'b1;
    step();
    call_i = 1'b0;
    chk("pre_flush_full", ras_empty_o, 0);
    flush = 1'b1; new_pc = 32'h400;
    step();
    flush = 1'b0;
    chk("flush_clear", ras_empty_o, 1);
`endif

    // mid-operation reset
    jump(32'h500);
    rst = 1'b1; stall = 6'b000001; branch_flag_i = 1'b1;
    branch_target_address_i = 32'h900;
    step();
    chk("mid_ce0", ce, 0);
    step();
    chk("mid_pc", pc, 32'h0);
    rst = 1'b0; stall = '0; branch_flag_i = 1'b0;
    step();
    chk("mid_ce1", ce, 1);
    chk("mid_pc0", pc, 32'h0);
    step();
    chk("mid_pc4", pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter AW, default 32, PC and address width in bits.
REQ-002 Parameter RESET_PC, default 32'h00000000 (AW bits), PC value while fetch is disabled.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, at least 2.
REQ-004 Parameter STALL_W, default 6, stall vector width; only bit 0 is consumed.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  exception/interrupt redirect request.
REQ-008 new_pc  in  AW  flush target address.
REQ-009 stall  in  STALL_W  pipeline stall vector; bit 0 = 1 freezes the PC stage.
REQ-010 branch_flag_i  in  1  resolved branch taken.
REQ-011 branch_target_address_i  in  AW  resolved branch target.
REQ-012 call_i  in  1  the instruction at the current pc is a call (jal/jalr).
REQ-013 ret_i  in  1  the instruction at the current pc is a return (jr $31).
REQ-014 pc  out  AW  current fetch address.
REQ-015 ce  out  1  instruction memory chip enable.
REQ-016 ras_hit_o  out  1  combinational; the next pc is being taken from the RAS this cycle.
REQ-017 ras_empty_o  out  1  RAS holds no valid entry.

Function
REQ-018 ce SHALL be registered: 0 in the cycle after rst=1, otherwise 1 in the cycle after rst=0.
REQ-019 When ce=0, pc SHALL load RESET_PC on every edge, and the RAS SHALL be cleared (count=0).
REQ-020 Define "advance" as ce=1 and stall[0]=0; with no advance, pc and the RAS SHALL hold, and call_i/ret_i SHALL be ignored.
REQ-021 On advance, the next pc SHALL be chosen by priority: flush -> new_pc; else branch_flag_i -> branch_target_address_i; else ret_i with RAS non-empty -> RAS top; else pc+4.
REQ-022 All pc arithmetic SHALL be modulo 2^AW; pc+4 from all-ones-minus-3 SHALL wrap to 0.
REQ-023 On advance with flush=1, the RAS SHALL be cleared, and call_i/ret_i SHALL be ignored.
REQ-024 On advance with branch_flag_i=1 and flush=0, the RAS SHALL be unchanged, and call_i/ret_i SHALL be ignored.
REQ-025 On a redirect-free advance with call_i=1, pc+8 (delay slot skipped) SHALL be pushed.
REQ-026 On a push while the RAS is full, the oldest entry SHALL be overwritten (circular), and the count SHALL saturate at RAS_DEPTH.
REQ-027 On a redirect-free advance with ret_i=1 and RAS non-empty, the top SHALL be popped and the count SHALL decrement.
REQ-028 On a redirect-free advance with ret_i=1 and RAS empty, the next pc SHALL be pc+4, and no state change other than pc SHALL occur.
REQ-029 call_i=ret_i=1 on a redirect-free advance with RAS non-empty SHALL take the next pc from the old top and replace the top with pc+8, leaving the count unchanged.
REQ-030 call_i=ret_i=1 on a redirect-free advance with RAS empty SHALL push pc+8, with next pc = pc+4.
REQ-031 ras_hit_o SHALL equal advance & !flush & !branch_flag_i & ret_i & !ras_empty_o.
REQ-032 ras_empty_o SHALL be 1 exactly when count=0.

Reset
REQ-033 rst=1 SHALL produce ce=0 after the next edge, then pc=RESET_PC, RAS count 0, and ras_empty_o=1 on the following edge and while held.
REQ-034 rst asserted mid-operation SHALL override stall, flush and branch, and fetch SHALL resume at RESET_PC two edges after rst drops.

Configuration
REQ-035 With macro PC_GEN_RAS_EN defined, the RAS SHALL be implemented as specified in REQ-021 through REQ-032.
REQ-036 Without PC_GEN_RAS_EN, no RAS storage SHALL exist, call_i/ret_i SHALL be ignored, the ret_i priority step SHALL be absent, ras_hit_o SHALL be constant 0, and ras_empty_o SHALL be constant 1.

Verification
REQ-037 Reset and ce: rst=1 for 3 cycles, then 0 -> ce goes 0 then 1, pc=0x0, then 0x4, then 0x8 on successive edges.
REQ-038 Priority: at pc=0x100, flush=1 (new_pc=0x380), branch_flag_i=1 (target 0x200) and ret_i=1 -> pc=0x380, RAS cleared.
REQ-039 Call/return: call_i=1 at pc=0x40, later ret_i=1 at pc=0x90 -> ras_hit_o=1 and pc=0x48 on the next edge, and ras_empty_o returns to 1.
REQ-040 Overflow: RAS_DEPTH=4, five calls at pc 0x10, 0x20, 0x30, 0x40, 0x50, then five returns -> pcs 0x58, 0x48, 0x38, 0x28, then pc+4 with ras_hit_o=0.
REQ-041 Stall: stall[0]=1 for 3 cycles with call_i=1 at pc=0x60 -> pc stays 0x60 and the RAS is unchanged.
REQ-042 Build without PC_GEN_RAS_EN: ret_i=1 after call_i=1 -> pc increments by 4, ras_hit_o=0.
